// File: rtl/axi_stream_insert_header.sv
// AXI-Stream header inserter: prepends 0..N header bytes to a packet
// and re-packs the stream into full, left-aligned output beats.
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam logic [BYTE_CNT_WD-1:0]  NB       = BYTE_CNT_WD'(DATA_BYTE_WD);
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

  function automatic logic [BYTE_CNT_WD-1:0] popcnt(
    input logic [DATA_BYTE_WD-1:0] k
  );
    popcnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      popcnt = popcnt + BYTE_CNT_WD'(k[i]);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_keep(
    input logic [BYTE_CNT_WD-1:0] n
  );
    top_keep = ~(KEEP_ALL >> n);
  endfunction

  state_t state, state_nxt;

  logic [DATA_WD-1:0]      carry, carry_nxt;
  logic [BYTE_CNT_WD-1:0]  h, h_nxt;
  logic                    load;
  logic [DATA_WD-1:0]      d_nxt;
  logic [DATA_BYTE_WD-1:0] k_nxt;
  logic                    l_nxt;

  logic                    free, beat, hdr, over;
  logic [DATA_WD-1:0]      din_m, hdr_m, shifted, low_mask, flush_bytes;
  logic [BYTE_CNT_WD-1:0]  k_cnt, nmh, rem;
  logic [BYTE_CNT_WD:0]    sum;

  // Bytes outside keep are forced to zero so unused output bytes are 0
  always_comb begin
    din_m = '0;
    hdr_m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      din_m[i*8 +: 8] = keep_in[i]     ? data_in[i*8 +: 8]     : 8'h00;
      hdr_m[i*8 +: 8] = keep_insert[i] ? data_insert[i*8 +: 8] : 8'h00;
    end
  end

  assign free         = !valid_out || ready_out;
  assign ready_in     = !rst && (state == STREAM) && free;
  assign ready_insert = !rst && (state == IDLE);
  assign beat         = valid_in && ready_in;
  assign hdr          = valid_insert && ready_insert;

  assign k_cnt    = popcnt(keep_in);
  assign sum      = {1'b0, h} + {1'b0, k_cnt};
  assign over     = sum > {1'b0, NB};
  assign rem      = BYTE_CNT_WD'(sum - {1'b0, NB});
  assign nmh      = NB - h;
  assign shifted  = DATA_WD'({carry, din_m} >> {h, 3'b000});
  assign low_mask = ~({DATA_WD{1'b1}} << {h, 3'b000});
  // Overflow bytes are stored already left-aligned for the flush beat
  assign flush_bytes = din_m << {nmh, 3'b000};

  always_comb begin
    state_nxt = state;
    carry_nxt = carry;
    h_nxt     = h;
    load      = 1'b0;
    d_nxt     = data_out;
    k_nxt     = keep_out;
    l_nxt     = last_out;
    unique case (state)
      IDLE: begin
        if (hdr) begin
          carry_nxt = hdr_m;
          h_nxt     = popcnt(keep_insert);
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (beat) begin
          load      = 1'b1;
          d_nxt     = shifted;
          k_nxt     = KEEP_ALL;
          l_nxt     = 1'b0;
          carry_nxt = din_m & low_mask;
          if (last_in && over) begin
            carry_nxt = flush_bytes;
            h_nxt     = rem;
            state_nxt = FLUSH;
          end else if (last_in) begin
            k_nxt     = top_keep(sum[BYTE_CNT_WD-1:0]);
            l_nxt     = 1'b1;
            carry_nxt = '0;
            h_nxt     = '0;
            state_nxt = IDLE;
          end
        end
      end
      FLUSH: begin
        if (free) begin
          load      = 1'b1;
          d_nxt     = carry;
          k_nxt     = top_keep(h);
          l_nxt     = 1'b1;
          carry_nxt = '0;
          h_nxt     = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry     <= '0;
      h         <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      carry <= carry_nxt;
      h     <= h_nxt;
      if (load) begin
        valid_out <= 1'b1;
        data_out  <= d_nxt;
        keep_out  <= k_nxt;
        last_out  <= l_nxt;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed scoreboard bench for axi_stream_insert_header (32-bit data).
module tb_axi_stream_insert_header;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic        ready_insert;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;

  axi_stream_insert_header #(.DATA_WD(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_insert (valid_insert),
    .data_insert  (data_insert),
    .keep_insert  (keep_insert),
    .ready_insert (ready_insert),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic acc_in, acc_hdr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k,
                      input logic l);
    exp_t e;
    e.d = d;
    e.k = k;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (valid_out && ready_out) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_beat: observed %h expected none", data_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data", data_out, e.d);
        chk("out_keep", {28'h0, keep_out}, {28'h0, e.k});
        chk("out_last", {31'h0, last_out}, {31'h0, e.l});
      end
    end
  endtask

  // Sample mid-cycle, then return 1 time unit after the next rising edge
  task automatic step();
    @(negedge clk);
    check_out();
    acc_in  = valid_in && ready_in;
    acc_hdr = valid_insert && ready_insert;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k,
                          output int cyc);
    valid_insert = 1'b1;
    data_insert  = d;
    keep_insert  = k;
    cyc = 0;
    acc_hdr = 1'b0;
    while (!acc_hdr && cyc < 20) begin
      step();
      cyc++;
    end
    if (!acc_hdr) chk("hdr_timeout", 32'(cyc), 32'd0);
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic l);
    int cyc;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    cyc = 0;
    acc_in = 1'b0;
    while (!acc_in && cyc < 20) begin
      step();
      cyc++;
    end
    if (!acc_in) chk("beat_timeout", 32'(cyc), 32'd0);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    ready_out = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || valid_out) && cyc < 50) begin
      step();
      cyc++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   c;
    logic [31:0] held;
    rst          = 1'b1;
    valid_in     = 1'b0;
    data_in      = '0;
    keep_in      = '0;
    last_in      = 1'b0;
    valid_insert = 1'b0;
    data_insert  = '0;
    keep_insert  = '0;
    ready_out    = 1'b1;
    step();
    step();
    chk("rst_ready_insert", {31'h0, ready_insert}, 32'd0);
    chk("rst_ready_in", {31'h0, ready_in}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_valid_out", {31'h0, valid_out}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_keep_out", {28'h0, keep_out}, 32'd0);
    chk("rst_last_out", {31'h0, last_out}, 32'd0);
    chk("idle_ready_insert", {31'h0, ready_insert}, 32'd1);
    chk("idle_ready_in", {31'h0, ready_in}, 32'd0);

    // 2-byte header, no flush
    push(32'hAABB1122, 4'hF, 1'b0);
    push(32'h33445566, 4'hF, 1'b1);
    send_hdr(32'h0000AABB, 4'b0011, c);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    drain();

    // 3-byte header, overflow into flush beat
    push(32'hCCDDEE11, 4'hF, 1'b0);
    push(32'h22330000, 4'b1100, 1'b1);
    send_hdr(32'h00CCDDEE, 4'b0111, c);
    send_beat(32'h11223344, 4'b1110, 1'b1);
    drain();

    // Empty header: pass-through, one cycle latency
    push(32'hDEADBEEF, 4'hF, 1'b0);
    push(32'h01000000, 4'b1000, 1'b1);
    send_hdr(32'h12345678, 4'b0000, c);
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    chk("lat_valid", {31'h0, valid_out}, 32'd1);
    chk("lat_data", data_out, 32'hDEADBEEF);
    send_beat(32'h01020304, 4'b1000, 1'b1);
    drain();

    // Stall 3 cycles mid-packet
    push(32'hAABB1122, 4'hF, 1'b0);
    push(32'h33445566, 4'hF, 1'b0);
    push(32'h778899AA, 4'hF, 1'b0);
    push(32'hBBCC0000, 4'b1100, 1'b1);
    send_hdr(32'h0000AABB, 4'b0011, c);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'hF, 1'b0);
    ready_out = 1'b0;
    held = data_out;
    chk("stall_held_value", held, 32'h33445566);
    valid_in = 1'b1;
    data_in  = 32'h99AABBCC;
    keep_in  = 4'hF;
    last_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_data_stable", data_out, held);
      chk("stall_valid", {31'h0, valid_out}, 32'd1);
      chk("stall_ready_in", {31'h0, ready_in}, 32'd0);
    end
    ready_out = 1'b1;
    send_beat(32'h99AABBCC, 4'hF, 1'b1);
    drain();

    // Reset during STREAM drops the in-flight beat
    ready_out = 1'b0;
    send_hdr(32'h0000AABB, 4'b0011, c);
    send_beat(32'h11223344, 4'hF, 1'b0);
    chk("pre_rst_valid", {31'h0, valid_out}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_mid_valid", {31'h0, valid_out}, 32'd0);
    chk("rst_mid_ready_insert", {31'h0, ready_insert}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_insert", {31'h0, ready_insert}, 32'd1);
    chk("post_rst_ready_in", {31'h0, ready_in}, 32'd0);
    ready_out = 1'b1;
    push(32'h99A1B2C3, 4'hF, 1'b0);
    push(32'hD4000000, 4'b1000, 1'b1);
    send_hdr(32'h00000099, 4'b0001, c);
    send_beat(32'hA1B2C3D4, 4'hF, 1'b1);
    drain();

    // Back-to-back: next header accepted while last beat is stalled
    push(32'hEE123400, 4'b1110, 1'b1);
    send_hdr(32'h000000EE, 4'b0001, c);
    ready_out = 1'b0;
    send_beat(32'h12345678, 4'b1100, 1'b1);
    send_hdr(32'hCAFEF00D, 4'hF, c);
    chk("b2b_hdr_cycles", 32'(c), 32'd1);
    chk("b2b_stalled_valid", {31'h0, valid_out}, 32'd1);
    chk("b2b_stalled_last", {31'h0, last_out}, 32'd1);
    ready_out = 1'b1;
    push(32'hCAFEF00D, 4'hF, 1'b0);
    push(32'h01020304, 4'hF, 1'b0);
    push(32'h05000000, 4'b1000, 1'b1);
    send_beat(32'h01020304, 4'hF, 1'b0);
    send_beat(32'h05060708, 4'b1000, 1'b1);
    drain();
    chk("end_valid_out", {31'h0, valid_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
